// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer, the IOPLL and the system reset controller.
// The sequencer uses the master modport; the PLL/reset-controller side uses the slave modport.
interface pll_reset_sequencer_if;
    logic       pll_locked;
    logic       sw_restart;
    logic       pll_rst;
    logic       sys_reset;
    logic       fault;
    logic [2:0] seq_state;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    modport master (
        input  pll_locked, sw_restart,
        output pll_rst, sys_reset, fault, seq_state, retry_cnt, lock_loss_cnt
    );

    modport slave (
        output pll_locked, sw_restart,
        input  pll_rst, sys_reset, fault, seq_state, retry_cnt, lock_loss_cnt
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Sequences IOPLL reset, waits for a qualified lock with bounded retries, then releases system reset.
// All outputs are registered from next-state so they move on the same edge as the state.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 4096,
    parameter int STABLE_CYCLES  = 256,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                  clk,
    input  logic                  n_reset,
    pll_reset_sequencer_if.master bus
);
    localparam int CNT_MAX = (PLL_RST_CYCLES > LOCK_TIMEOUT)
                           ? ((PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES)
                           : ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_LAST  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    state_t                 state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [3:0]             retry, retry_n;
    logic [7:0]             loss, loss_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state             <= PLL_RST;
            cnt               <= '0;
            retry             <= '0;
            loss              <= '0;
            bus.pll_rst       <= 1'b1;
            bus.sys_reset     <= 1'b1;
            bus.fault         <= 1'b0;
            bus.seq_state     <= 3'd0;
            bus.retry_cnt     <= 4'd0;
            bus.lock_loss_cnt <= 8'd0;
        end else begin
            state             <= state_n;
            cnt               <= cnt_n;
            retry             <= retry_n;
            loss              <= loss_n;
            bus.pll_rst       <= (state_n == PLL_RST);
            bus.sys_reset     <= (state_n != RUN);
            bus.fault         <= (state_n == FAULT);
            bus.seq_state     <= state_n;
            bus.retry_cnt     <= retry_n;
            bus.lock_loss_cnt <= loss_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        retry_n = retry;
        loss_n  = loss;
        case (state)
            PLL_RST: begin
                if (cnt == RST_LAST) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_n = STABLE;
                    cnt_n   = '0;
                end else if (cnt == LOCK_LAST && retry == RETRY_LAST) begin
                    state_n = FAULT;
                    cnt_n   = '0;
                end else if (cnt == LOCK_LAST) begin
                    state_n = PLL_RST;
                    cnt_n   = '0;
                    retry_n = retry + 4'd1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STABLE: begin
                // A lock drop restarts the lock timeout but does not consume a retry.
                if (!lock_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_n = PLL_RST;
                    cnt_n   = '0;
                    retry_n = '0;
                    loss_n  = (loss == 8'hFF) ? loss : loss + 8'd1;
                end
            end
            FAULT: ;
            default: begin
                state_n = PLL_RST;
                cnt_n   = '0;
            end
        endcase
        // Restart overrides everything except the lock-loss count computed above.
        if (bus.sw_restart) begin
            state_n = PLL_RST;
            cnt_n   = '0;
            retry_n = '0;
        end
    end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: bring-up, retries to FAULT, STABLE glitch,
// lock loss with saturation, sw_restart and asynchronous mid-run reset.
module tb_pll_reset_sequencer;
    logic clk = 1'b0;
    logic n_reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    pll_reset_sequencer_if bus();

    pll_reset_sequencer #(
        .SYNC_STAGES(2), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(32),
        .STABLE_CYCLES(8), .MAX_RETRIES(2)
    ) dut (
        .clk(clk),
        .n_reset(n_reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int highs;
        int rises;
        logic prev;

        n_reset        = 1'b0;
        bus.pll_locked = 1'b1;
        bus.sw_restart = 1'b0;
        tick(3);
        chk("rst_pll_rst", 32'(bus.pll_rst), 1);
        chk("rst_sys_reset", 32'(bus.sys_reset), 1);
        chk("rst_fault", 32'(bus.fault), 0);
        chk("rst_state", 32'(bus.seq_state), 0);
        chk("rst_retry", 32'(bus.retry_cnt), 0);
        chk("rst_loss", 32'(bus.lock_loss_cnt), 0);

        // Nominal bring-up with lock already high
        n_reset = 1'b1;
        tick(3);
        chk("nom_e3_state", 32'(bus.seq_state), 0);
        chk("nom_e3_pll_rst", 32'(bus.pll_rst), 1);
        tick(1);
        chk("nom_e4_state", 32'(bus.seq_state), 1);
        chk("nom_e4_pll_rst", 32'(bus.pll_rst), 0);
        tick(1);
        chk("nom_e5_state", 32'(bus.seq_state), 2);
        tick(7);
        chk("nom_e12_state", 32'(bus.seq_state), 2);
        chk("nom_e12_sys_reset", 32'(bus.sys_reset), 1);
        tick(1);
        chk("nom_e13_state", 32'(bus.seq_state), 3);
        chk("nom_e13_sys_reset", 32'(bus.sys_reset), 0);
        chk("nom_retry", 32'(bus.retry_cnt), 0);

        // Lock loss in RUN: sys_reset reasserts on the third edge
        bus.pll_locked = 1'b0;
        tick(2);
        chk("loss_e2_sys_reset", 32'(bus.sys_reset), 0);
        tick(1);
        chk("loss_e3_sys_reset", 32'(bus.sys_reset), 1);
        chk("loss_e3_state", 32'(bus.seq_state), 0);
        chk("loss_e3_loss", 32'(bus.lock_loss_cnt), 1);
        chk("loss_e3_pll_rst", 32'(bus.pll_rst), 1);
        bus.pll_locked = 1'b1;
        tick(3);
        chk("loss_pulse_last", 32'(bus.pll_rst), 1);
        tick(1);
        chk("loss_pulse_end", 32'(bus.pll_rst), 0);
        chk("loss_wait_state", 32'(bus.seq_state), 1);
        tick(1);
        chk("loss_stable_state", 32'(bus.seq_state), 2);

        // Three-cycle lock glitch in STABLE
        tick(3);
        bus.pll_locked = 1'b0;
        tick(3);
        chk("glitch_back_wait", 32'(bus.seq_state), 1);
        chk("glitch_no_pll_rst", 32'(bus.pll_rst), 0);
        bus.pll_locked = 1'b1;
        tick(2);
        chk("glitch_still_wait", 32'(bus.seq_state), 1);
        tick(1);
        chk("glitch_restable", 32'(bus.seq_state), 2);
        chk("glitch_retry", 32'(bus.retry_cnt), 0);
        tick(7);
        chk("glitch_requal_state", 32'(bus.seq_state), 2);
        tick(1);
        chk("glitch_run_state", 32'(bus.seq_state), 3);
        chk("glitch_run_sys_reset", 32'(bus.sys_reset), 0);

        // 299 more losses; counter saturates at 255
        for (int i = 0; i < 299; i++) begin
            bus.pll_locked = 1'b0;
            tick(3);
            bus.pll_locked = 1'b1;
            tick(13);
            if (i == 252) chk("sat_254", 32'(bus.lock_loss_cnt), 254);
            if (i == 253) chk("sat_255", 32'(bus.lock_loss_cnt), 255);
        end
        chk("sat_hold", 32'(bus.lock_loss_cnt), 255);
        chk("sat_run_state", 32'(bus.seq_state), 3);

        // Asynchronous reset between edges
        #3;
        n_reset = 1'b0;
        #1;
        chk("async_pll_rst", 32'(bus.pll_rst), 1);
        chk("async_sys_reset", 32'(bus.sys_reset), 1);
        chk("async_state", 32'(bus.seq_state), 0);
        chk("async_loss", 32'(bus.lock_loss_cnt), 0);
        chk("async_retry", 32'(bus.retry_cnt), 0);
        n_reset = 1'b1;
        tick(13);
        chk("rebring_state", 32'(bus.seq_state), 3);

        // sw_restart coinciding with lock loss in RUN
        bus.pll_locked = 1'b0;
        tick(2);
        bus.sw_restart = 1'b1;
        tick(1);
        bus.sw_restart = 1'b0;
        chk("swloss_state", 32'(bus.seq_state), 0);
        chk("swloss_loss", 32'(bus.lock_loss_cnt), 1);
        chk("swloss_retry", 32'(bus.retry_cnt), 0);
        chk("swloss_sys_reset", 32'(bus.sys_reset), 1);

        // Lock never arrives: three pulses then FAULT
        highs = 1;
        rises = 1;
        prev  = bus.pll_rst;
        for (int j = 1; j <= 210; j++) begin
            tick(1);
            if (bus.pll_rst) highs++;
            if (bus.pll_rst && !prev) rises++;
            prev = bus.pll_rst;
            if (j == 4)   chk("nolock_t4_state", 32'(bus.seq_state), 1);
            if (j == 35)  chk("nolock_t35_state", 32'(bus.seq_state), 1);
            if (j == 36)  chk("nolock_t36_retry", 32'(bus.retry_cnt), 1);
            if (j == 36)  chk("nolock_t36_state", 32'(bus.seq_state), 0);
            if (j == 72)  chk("nolock_t72_retry", 32'(bus.retry_cnt), 2);
            if (j == 107) chk("nolock_t107_fault", 32'(bus.fault), 0);
            if (j == 108) chk("nolock_t108_state", 32'(bus.seq_state), 4);
        end
        chk("nolock_pulse_cycles", 32'(highs), 12);
        chk("nolock_pulses", 32'(rises), 3);
        chk("fault_state", 32'(bus.seq_state), 4);
        chk("fault_flag", 32'(bus.fault), 1);
        chk("fault_retry", 32'(bus.retry_cnt), 2);
        chk("fault_sys_reset", 32'(bus.sys_reset), 1);
        chk("fault_pll_rst", 32'(bus.pll_rst), 0);

        // sw_restart out of FAULT
        bus.sw_restart = 1'b1;
        tick(1);
        bus.sw_restart = 1'b0;
        chk("swf_fault", 32'(bus.fault), 0);
        chk("swf_state", 32'(bus.seq_state), 0);
        chk("swf_retry", 32'(bus.retry_cnt), 0);
        chk("swf_loss", 32'(bus.lock_loss_cnt), 1);
        chk("swf_pll_rst", 32'(bus.pll_rst), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Refclk-domain controller that sequences IOPLL bring-up and gates system reset release.
- Pulses the IOPLL reset, waits for lock with timeout and bounded retries, and qualifies lock stability before releasing the Qsys system reset.
- Re-sequences on lock loss or a software restart request.
- Sits between the reset-release IP / IOPLL and the qsys_top reset controller input; replaces the bare inverted-lock connection.

Parameters:
- SYNC_STAGES, 2: synchronizer depth for the asynchronous pll_locked input (minimum 2).
- PLL_RST_CYCLES, 16: cycles pll_rst is held high per PLL reset pulse (minimum 1).
- LOCK_TIMEOUT, 4096: cycles allowed in WAIT_LOCK before a retry (minimum 1).
- STABLE_CYCLES, 256: consecutive synchronized-lock cycles required before release (minimum 1).
- MAX_RETRIES, 3: retries allowed after the first attempt before FAULT; 0 to 15.

Ports:
- clk  in  1  refclk, free-running, independent of the PLL.
- n_reset  in  1  asynchronous active-low reset; deassertion synchronized externally.
- pll_locked  in  1  IOPLL locked; asynchronous to clk.
- sw_restart  in  1  single-cycle synchronous pulse; forces a full re-sequence.
- pll_rst  out  1  IOPLL reset, active-high.
- sys_reset  out  1  system reset to the Qsys reset controller, active-high.
- fault  out  1  high in FAULT.
- seq_state  out  3  current state encoding.
- retry_cnt  out  4  retries used in the current sequence.
- lock_loss_cnt  out  8  lock losses seen in RUN; saturates at 255.

Behaviour:
- **Lock synchronization:** pll_locked passes through SYNC_STAGES flops to produce lock_s. All decisions use lock_s only.
- **Registered outputs:** all outputs are registered and decoded from next-state, so they change on the same edge as the state.
- **State encoding:** 0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAULT. Codes 5-7 go to PLL_RST on the next edge.
- **Reset (n_reset=0, asynchronous):**
  - state=PLL_RST, cnt=0.
  - pll_rst=1, sys_reset=1, fault=0.
  - retry_cnt=0, lock_loss_cnt=0, seq_state=0, synchronizer cleared.
- **Output decode:**
  - pll_rst=1 only in PLL_RST.
  - sys_reset=0 only in RUN.
  - fault=1 only in FAULT.
- **PLL_RST:** cnt increments each edge. When cnt==PLL_RST_CYCLES-1: go to WAIT_LOCK, cnt=0.
- **WAIT_LOCK:**
  - If lock_s=1: go to STABLE, cnt=0.
  - Else if cnt==LOCK_TIMEOUT-1 and retry_cnt==MAX_RETRIES: go to FAULT.
  - Else if cnt==LOCK_TIMEOUT-1: retry_cnt+1, go to PLL_RST, cnt=0.
  - Otherwise cnt+1.
- **STABLE:**
  - If lock_s=0: go to WAIT_LOCK, cnt=0. retry_cnt is unchanged and the timeout restarts.
  - Else if cnt==STABLE_CYCLES-1: go to RUN.
  - Otherwise cnt+1.
- **RUN:** if lock_s=0, lock_loss_cnt+1 (saturating), retry_cnt=0, go to PLL_RST, cnt=0.
- **FAULT:** terminal. pll_rst=0, sys_reset=1. Exits only via n_reset or sw_restart.
- **sw_restart:**
  - Highest priority, in any state: go to PLL_RST, cnt=0, retry_cnt=0, fault cleared next edge.
  - lock_loss_cnt is kept.
  - If sw_restart coincides with lock loss in RUN, lock_loss_cnt still increments.
- **Latency:**
  - pll_locked fall in RUN to sys_reset=1: SYNC_STAGES+1 edges.
  - Minimum n_reset release to sys_reset=0 (lock already high): PLL_RST_CYCLES+STABLE_CYCLES+1 edges.
- **Counter sizing:** cnt width is clog2 of the largest of PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES. No wrap is reachable.

Test Plan:
All tests use SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.
- **Nominal bring-up:** pll_locked=1 throughout, release n_reset -> pll_rst high through edge 4; seq_state 1 at edge 4, 2 at edge 5, 3 at edge 13; sys_reset falls after edge 13; retry_cnt=0.
- **Lock never arrives:** pll_locked=0 -> exactly 3 pll_rst pulses of 4 cycles, each separated by 32 WAIT_LOCK cycles; then seq_state=4, fault=1, retry_cnt=2, sys_reset=1, pll_rst=0 indefinitely.
- **Lock glitch in STABLE:** drop pll_locked for 3 cycles midway through STABLE -> return to WAIT_LOCK, then STABLE; full 8-cycle qualification restarts; no pll_rst pulse; retry_cnt unchanged.
- **Lock loss in RUN:** drop pll_locked -> sys_reset=1 within 3 edges, lock_loss_cnt=1, 4-cycle pll_rst pulse, re-release after requalification. Repeat 300 times -> lock_loss_cnt holds 255.
- **sw_restart:** pulse in FAULT -> fault=0 and seq_state=0 next edge, retry_cnt=0, lock_loss_cnt preserved. Pulse together with lock loss in RUN -> PLL_RST, lock_loss_cnt+1.
- **Mid-operation reset:** assert n_reset asynchronously in RUN (between edges) -> pll_rst=1, sys_reset=1, all counters 0 immediately, without waiting for a clk edge.
